// File: rtl/vga_port_arbiter_pkg.sv
// Shared definitions for the VGA write-port arbiter, the VGA adapter and the draw engines.
// Holds state encodings, default pixel widths and requester slot numbers.
package vga_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int VGA_X_W      = 8;
  localparam int VGA_Y_W      = 7;
  localparam int VGA_COLOUR_W = 3;

  localparam int REQ_SCREEN  = 0;
  localparam int REQ_MAZE    = 1;
  localparam int REQ_BOX     = 2;
  localparam int REQ_SPECIAL = 3;

endpackage

// File: rtl/vga_port_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first set request after rr_ptr,
// wrapping modulo N, and returns it one-hot together with a valid bit.
module vga_port_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[(int'(rr_ptr) + k) % N]) begin
        winner[(int'(rr_ptr) + k) % N] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_port_arbiter.sv
// Shares the single VGA framebuffer write port among NUM_REQ draw engines with
// round-robin grants, a 1-cycle registered pixel path and a hung-engine watchdog.
module vga_port_arbiter
  import vga_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int X_W      = VGA_X_W,
  parameter int Y_W      = VGA_Y_W,
  parameter int COLOUR_W = VGA_COLOUR_W,
  parameter int TIMEOUT  = 20000,
  parameter int CNT_W    = 15
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        abort,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          eng_done,
  input  logic [NUM_REQ*X_W-1:0]      eng_x,
  input  logic [NUM_REQ*Y_W-1:0]      eng_y,
  input  logic [NUM_REQ*COLOUR_W-1:0] eng_colour,
  input  logic [NUM_REQ-1:0]          eng_plot,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done_out,
  output logic [X_W-1:0]              vga_x,
  output logic [Y_W-1:0]              vga_y,
  output logic [COLOUR_W-1:0]         vga_colour,
  output logic                        vga_plot,
  output logic                        busy,
  output logic                        timeout_flag,
  output arb_state_t                  arb_state
);

  // Handshake: an engine holds req high until it pulses eng_done; it owns the
  // port only while its grant bit is set, and its plots are ignored otherwise.

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         state, state_next;
  logic [NUM_REQ-1:0] winner;
  logic               win_valid;
  logic [PTR_W-1:0]   rr_ptr, g_idx, win_idx;
  logic [CNT_W-1:0]   cnt;
  logic               end_abort, end_done, end_drop, end_wd, leave;

  vga_port_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= ARB_IDLE;
    else         state <= state_next;
  end

  // Release causes are mutually exclusive, highest priority first.
  always_comb begin
    state_next = state;
    end_abort  = 1'b0;
    end_done   = 1'b0;
    end_drop   = 1'b0;
    end_wd     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (win_valid) state_next = ARB_GRANT;
      end
      ARB_GRANT: begin
        if (abort)                                             end_abort = 1'b1;
        else if (eng_done[g_idx])                              end_done  = 1'b1;
        else if (!req[g_idx])                                  end_drop  = 1'b1;
        else if ((TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1))) end_wd    = 1'b1;
        if (end_abort || end_done || end_drop || end_wd) state_next = ARB_RELEASE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign leave     = (state == ARB_GRANT) && (state_next == ARB_RELEASE);
  assign busy      = (state != ARB_IDLE);
  assign arb_state = state;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      grant        <= '0;
      done_out     <= '0;
      g_idx        <= '0;
      rr_ptr       <= PTR_W'(NUM_REQ - 1);
      cnt          <= '0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      vga_plot     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      done_out <= '0;
      vga_plot <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (win_valid) begin
            grant <= winner;
            g_idx <= win_idx;
            cnt   <= '0;
          end
        end
        ARB_GRANT: begin
          cnt <= cnt + 1'b1;
          // Coordinates only move with a forwarded plot; an aborted pixel is dropped.
          if (eng_plot[g_idx] && !abort) begin
            vga_plot   <= 1'b1;
            vga_x      <= eng_x[g_idx*X_W +: X_W];
            vga_y      <= eng_y[g_idx*Y_W +: Y_W];
            vga_colour <= eng_colour[g_idx*COLOUR_W +: COLOUR_W];
          end
          if (leave) begin
            grant  <= '0;
            rr_ptr <= g_idx;
          end
          if (end_done) done_out <= grant;
          if (end_wd)   timeout_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Bench for vga_port_arbiter: directed scenarios pinned by literal values, then
// random traffic compared each cycle against a transaction-level owner model.
module tb_vga_port_arbiter;
  import vga_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            abort = 1'b0;
  logic [N-1:0]    req = '0, eng_done = '0, eng_plot = '0;
  logic [N*XW-1:0] eng_x = '0;
  logic [N*YW-1:0] eng_y = '0;
  logic [N*CW-1:0] eng_colour = '0;
  logic [N-1:0]    grant, done_out;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot, busy, timeout_flag;
  arb_state_t      arb_state;

  always #5 clock = ~clock;

  vga_port_arbiter #(
    .NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .TIMEOUT(TO), .CNT_W(15)
  ) dut (
    .clock(clock), .resetn(resetn), .abort(abort), .req(req), .eng_done(eng_done),
    .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour), .eng_plot(eng_plot),
    .grant(grant), .done_out(done_out), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .timeout_flag(timeout_flag), .arb_state(arb_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: who owns the port, how long it has held it, whether a release cycle is pending.
  int            m_owner = -1;
  int            m_last  = N - 1;
  int            m_held  = 0;
  bit            m_rel   = 1'b0;
  logic [N-1:0]  e_grant = '0, e_done = '0;
  logic          e_plot = 1'b0, e_flag = 1'b0;
  logic [XW-1:0] e_x = '0;
  logic [YW-1:0] e_y = '0;
  logic [CW-1:0] e_c = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int idx;
    bit fin;
    e_done = '0;
    e_plot = 1'b0;
    if (!resetn) begin
      m_owner = -1; m_rel = 1'b0; m_last = N - 1; m_held = 0;
      e_grant = '0; e_flag = 1'b0; e_x = '0; e_y = '0; e_c = '0;
      return;
    end
    if (m_owner >= 0) begin
      m_held++;
      if (eng_plot[m_owner] && !abort) begin
        e_plot = 1'b1;
        e_x = eng_x[m_owner*XW +: XW];
        e_y = eng_y[m_owner*YW +: YW];
        e_c = eng_colour[m_owner*CW +: CW];
      end
      fin = abort || eng_done[m_owner] || !req[m_owner] || (m_held == TO);
      if (fin) begin
        if (!abort && eng_done[m_owner]) e_done[m_owner] = 1'b1;
        else if (!abort && req[m_owner]) e_flag = 1'b1;
        m_last = m_owner; m_owner = -1; m_rel = 1'b1; e_grant = '0;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (req != '0) begin
      idx = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (req[idx]) break;
      end
      m_owner = idx; m_held = 0;
      e_grant = '0; e_grant[idx] = 1'b1;
    end
  endtask

  task automatic compare();
    arb_state_t es;
    es = (m_owner >= 0) ? ARB_GRANT : (m_rel ? ARB_RELEASE : ARB_IDLE);
    n_vec++;
    check("grant", 32'(grant), 32'(e_grant));
    check("done_out", 32'(done_out), 32'(e_done));
    check("vga_plot", 32'(vga_plot), 32'(e_plot));
    check("vga_x", 32'(vga_x), 32'(e_x));
    check("vga_y", 32'(vga_y), 32'(e_y));
    check("vga_colour", 32'(vga_colour), 32'(e_c));
    check("busy", 32'(busy), 32'(m_owner >= 0 || m_rel));
    check("timeout_flag", 32'(timeout_flag), 32'(e_flag));
    check("arb_state", 32'(arb_state), 32'(es));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic wait_grant(input string name);
    int w;
    w = 0;
    while (grant == '0 && w < 10) begin
      tick();
      w++;
    end
    if (grant == '0) begin
      n_err++;
      $display("FAIL %s: no grant after %0d cycles", name, w);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int rr_exp[4];
    int g, idle, waited, cnt;
    rr_exp = '{0, 1, 3, 0};

    // Reset with every engine requesting; engine 0 must win first.
    resetn = 1'b0; req = 4'b1111;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_plot", 32'(vga_plot), 32'h0);
    check("rst_flag", 32'(timeout_flag), 32'h0);
    resetn = 1'b1;
    tick();
    check("first_grant", 32'(grant), 32'h1);
    eng_done[REQ_SCREEN] = 1'b1; req = '0;
    tick();
    check("coincident_done", 32'(done_out), 32'h1);
    eng_done = '0;
    repeat (2) tick();

    // Forwarding from engine 2 while engine 1 plots alongside.
    req[REQ_BOX] = 1'b1;
    tick();
    check("fwd_grant", 32'(grant), 32'h4);
    eng_x[REQ_BOX*XW +: XW] = 8'd40; eng_y[REQ_BOX*YW +: YW] = 7'd30; eng_colour[REQ_BOX*CW +: CW] = 3'b101;
    eng_x[REQ_MAZE*XW +: XW] = 8'd99; eng_y[REQ_MAZE*YW +: YW] = 7'd99; eng_colour[REQ_MAZE*CW +: CW] = 3'b010;
    eng_plot = 4'b0110; eng_done[REQ_MAZE] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      eng_done = '0;
      check("fwd_x", 32'(vga_x), 32'd40);
      check("fwd_y", 32'(vga_y), 32'd30);
      check("fwd_colour", 32'(vga_colour), 32'd5);
      check("fwd_plot", 32'(vga_plot), 32'd1);
      check("fwd_hold", 32'(grant), 32'h4);
    end
    eng_plot = '0; eng_done[REQ_BOX] = 1'b1;
    tick();
    check("fwd_done", 32'(done_out), 32'h4);
    eng_done = '0; req = '0;
    repeat (2) tick();

    // Round-robin over engines 0, 1 and 3 from a fresh reset.
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1; req = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      idle = 0; waited = 0;
      while (grant == '0 && waited < 10) begin
        tick();
        waited++;
        if (!busy) idle++;
      end
      g = onehot_idx(grant);
      check("rr_order", 32'(g), 32'(rr_exp[n]));
      if (n > 0) check("rr_gap", 32'(idle), 32'd1);
      repeat (4) tick();
      if (g >= 0) eng_done[g] = 1'b1;
      tick();
      eng_done = '0;
      check("rr_done", 32'(done_out), 32'(1 << rr_exp[n]));
    end
    req = '0;
    repeat (2) tick();

    // Abort mid-grant of engine 1, then the next pick must start after index 1.
    req[REQ_MAZE] = 1'b1;
    wait_grant("abort_wait");
    check("abort_grant1", 32'(grant), 32'h2);
    eng_plot = 4'b0010;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_grant", 32'(grant), 32'h0);
    check("abort_done", 32'(done_out), 32'h0);
    check("abort_plot", 32'(vga_plot), 32'h0);
    req = 4'b1011;
    repeat (2) tick();
    check("abort_next", 32'(grant), 32'h8);
    eng_done[REQ_SPECIAL] = 1'b1; req = '0; eng_plot = '0;
    tick();
    eng_done = '0;
    repeat (2) tick();

    // Watchdog on engine 3 which never finishes.
    req[REQ_SPECIAL] = 1'b1;
    wait_grant("wd_wait");
    cnt = (grant == 4'b1000) ? 1 : 0;
    while (grant == 4'b1000 && cnt < 40) begin
      tick();
      if (grant == 4'b1000) cnt++;
    end
    check("wd_len", 32'(cnt), 32'd16);
    check("wd_flag", 32'(timeout_flag), 32'd1);
    check("wd_done", 32'(done_out), 32'd0);
    req = '0;
    repeat (3) tick();
    check("wd_flag_sticky", 32'(timeout_flag), 32'd1);

    // Reset in the middle of a grant drops the pixel in flight.
    req[REQ_SCREEN] = 1'b1;
    wait_grant("rst_mid_wait");
    eng_plot = 4'b0001;
    tick();
    resetn = 1'b0;
    tick();
    check("rst_mid_grant", 32'(grant), 32'h0);
    check("rst_mid_plot", 32'(vga_plot), 32'h0);
    check("rst_mid_flag", 32'(timeout_flag), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    resetn = 1'b1; req = '0; eng_plot = '0;
    tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        eng_done[i] = ($urandom_range(0, 9) == 0);
        if (eng_done[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
      end
      eng_plot   = N'($urandom);
      eng_x      = (N*XW)'($urandom);
      eng_y      = (N*YW)'($urandom);
      eng_colour = (N*CW)'($urandom);
      abort      = ($urandom_range(0, 39) == 0);
      resetn     = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
